up_down_counter: RTL and testbench



---
 rtl/up_down_counter_pkg.sv | 16 +
 rtl/up_down_counter.sv | 96 +++++++++
 tb/tb_up_down_counter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/up_down_counter_pkg.sv
// Shared definitions for the up/down counter.
// Contents:
//   DIR_UP / DIR_DOWN  - encodings of the up_down direction input
//   ctrl_t             - per-cycle control bundle (en, up_down, load)
package up_down_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef struct packed {
    logic en;
    logic up_down;
    logic load;
  } ctrl_t;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter.sv
// Parameterised synchronous up/down counter with enable, parallel load and
// terminal-count / wrap flags.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset (count <= RST_VAL, wrap <= 0)
//   en        in   count enable, count holds when low
//   up_down   in   direction, 1 = up, 0 = down
//   load      in   synchronous parallel load strobe (beats en)
//   load_val  in   value taken when load is high
//   count     out  current count (registered)
//   tc        out  terminal count, combinational from count and up_down
//   wrap      out  one-cycle registered pulse after a wrap-around step
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             wrap_nxt_s;
  logic             tc_s;
  ctrl_t            ctrl_s;

  // Next-state selection (load > count step > hold) and terminal-count flag.
  always_comb begin
    ctrl_s      = '{en: en, up_down: up_down, load: load};
    count_nxt_s = count_r;
    wrap_nxt_s  = 1'b0;
    tc_s        = 1'b0;

    if (ctrl_s.load) begin
      count_nxt_s = load_val;
      wrap_nxt_s  = 1'b0;
    end else if (ctrl_s.en) begin
      // Carry/borrow out of the top bit is dropped; the wrap flag records it.
      case (ctrl_s.up_down)
        DIR_UP: begin
          count_nxt_s = count_r + CNT_ONE;
          wrap_nxt_s  = (count_r == CNT_MAX);
        end
        DIR_DOWN: begin
          count_nxt_s = count_r - CNT_ONE;
          wrap_nxt_s  = (count_r == CNT_ZERO);
        end
        default: begin
          count_nxt_s = count_r;
          wrap_nxt_s  = 1'b0;
        end
      endcase
    end else begin
      count_nxt_s = count_r;
      wrap_nxt_s  = 1'b0;
    end

    // tc looks at the direction currently applied, so it flips with up_down
    // even while the count is held.
    if (ctrl_s.up_down == DIR_UP) begin
      tc_s = (count_r == CNT_MAX);
    end else begin
      tc_s = (count_r == CNT_ZERO);
    end
  end

  // Count and wrap registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= RST_VAL;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  assign count = count_r;
  assign wrap  = wrap_r;
  assign tc    = tc_s;

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// Directed self-checking bench for up_down_counter (WIDTH=4, RST_VAL=0),
// followed by a short randomised run against a small reference model.
module tb_up_down_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_down;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc;
  logic       wrap;

  int total = 0;
  int bad   = 0;

  up_down_counter #(
    .WIDTH   (4),
    .RST_VAL (4'd0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_down  (up_down),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One rising edge, then settle 1 ns so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;
    int exp_wrap;
    int exp_tc;

    rst      = 1'b0;
    en       = 1'b1;
    up_down  = 1'b1;
    load     = 1'b0;
    load_val = 4'd0;

    // Reset held for two edges with en=1: count stays 0, wrap stays 0.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_count", {28'd0, count}, 32'd0);
      chk("rst_wrap", {31'd0, wrap}, 32'd0);
    end

    // Count up through the wrap: 1..15, 0, 1.
    rst = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      exp_cnt  = i % 16;
      exp_tc   = (exp_cnt == 15) ? 1 : 0;
      exp_wrap = (i == 16) ? 1 : 0;
      chk("up_count", {28'd0, count}, exp_cnt);
      chk("up_tc", {31'd0, tc}, exp_tc);
      chk("up_wrap", {31'd0, wrap}, exp_wrap);
    end

    // Asynchronous reset mid-count: count is 1 now, drops to 0 without an edge.
    en  = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_count", {28'd0, count}, 32'd0);
    #1;
    rst = 1'b1;

    // Load 2, then count down: 1, 0, 15, 14.
    load     = 1'b1;
    load_val = 4'd2;
    step();
    chk("load2", {28'd0, count}, 32'd2);
    load    = 1'b0;
    up_down = 1'b0;
    en      = 1'b1;
    step();
    chk("dn_count_1", {28'd0, count}, 32'd1);
    chk("dn_tc_1", {31'd0, tc}, 32'd0);
    chk("dn_wrap_1", {31'd0, wrap}, 32'd0);
    step();
    chk("dn_count_0", {28'd0, count}, 32'd0);
    chk("dn_tc_0", {31'd0, tc}, 32'd1);
    chk("dn_wrap_0", {31'd0, wrap}, 32'd0);
    step();
    chk("dn_count_15", {28'd0, count}, 32'd15);
    chk("dn_tc_15", {31'd0, tc}, 32'd0);
    chk("dn_wrap_15", {31'd0, wrap}, 32'd1);
    step();
    chk("dn_count_14", {28'd0, count}, 32'd14);
    chk("dn_wrap_14", {31'd0, wrap}, 32'd0);

    // Load wins over a simultaneous count step.
    load     = 1'b1;
    load_val = 4'd9;
    en       = 1'b1;
    up_down  = 1'b1;
    step();
    chk("load_prio", {28'd0, count}, 32'd9);
    load = 1'b0;
    step();
    chk("after_load", {28'd0, count}, 32'd10);
    chk("after_load_wrap", {31'd0, wrap}, 32'd0);

    // Hold for 5 cycles.
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_count", {28'd0, count}, 32'd10);
      chk("hold_wrap", {31'd0, wrap}, 32'd0);
    end

    // Direction toggles while held change only tc (load 15 first).
    load     = 1'b1;
    load_val = 4'd15;
    step();
    load    = 1'b0;
    up_down = 1'b1;
    #1;
    chk("tc_up_at15", {31'd0, tc}, 32'd1);
    up_down = 1'b0;
    #1;
    chk("tc_dn_at15", {31'd0, tc}, 32'd0);
    up_down = 1'b1;
    step();
    chk("tc_hold_count", {28'd0, count}, 32'd15);
    chk("tc_up_again", {31'd0, tc}, 32'd1);

    // Wrap up from 15, then a hold must clear the wrap pulse.
    en = 1'b1;
    step();
    chk("wrap_up_count", {28'd0, count}, 32'd0);
    chk("wrap_up_pulse", {31'd0, wrap}, 32'd1);
    en = 1'b0;
    step();
    chk("wrap_hold_count", {28'd0, count}, 32'd0);
    chk("wrap_hold_clear", {31'd0, wrap}, 32'd0);

    // Random stimulus for 50 cycles against a reference model.
    exp_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      en       = 1'($urandom_range(1, 0));
      up_down  = 1'($urandom_range(1, 0));
      load     = ($urandom_range(7, 0) == 0) ? 1'b1 : 1'b0;
      load_val = 4'($urandom_range(15, 0));
      #1;
      exp_tc = up_down ? ((exp_cnt == 15) ? 1 : 0) : ((exp_cnt == 0) ? 1 : 0);
      chk("rnd_tc", {31'd0, tc}, exp_tc);
      exp_wrap = 0;
      if (load) begin
        exp_cnt = load_val;
      end else if (en && up_down) begin
        exp_wrap = (exp_cnt == 15) ? 1 : 0;
        exp_cnt  = (exp_cnt + 1) % 16;
      end else if (en) begin
        exp_wrap = (exp_cnt == 0) ? 1 : 0;
        exp_cnt  = (exp_cnt + 15) % 16;
      end
      step();
      chk("rnd_count", {28'd0, count}, exp_cnt);
      chk("rnd_wrap", {31'd0, wrap}, exp_wrap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_up_down_counter
